// File: rtl/dmaread_if.sv
// rtl/dmaread_if.sv - AXI3 read address/data channel bundle for the frame-buffer read DMA
interface dmaread_if;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rvalid, rlast
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rvalid, rlast
  );
endinterface

// File: rtl/dmaread.sv
// rtl/dmaread.sv - frame-buffer read DMA: one frame per dmastart, credit-limited AXI3 bursts into the pixel FIFO
module dmaread #(
  parameter int BURST   = 16,
  parameter int MAXOUT  = 4,
  parameter int ATTRMAX = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ATTRMAX:0]   attr,
  input  logic [31:0]        base,
  input  logic               dmastart,
  dmaread_if.master          axi,
  output logic [63:0]        fifo_wdata,
  output logic               fifo_wr,
  input  logic [9:0]         fifo_free,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int PW = (MAXOUT > 1) ? $clog2(MAXOUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;

  logic [31:0]   addr;
  logic [31:0]   remain;
  logic [9:0]    resv;
  logic [3:0]    outst;
  logic [3:0]    lenq [MAXOUT];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [3:0]    bcnt;

  logic [31:0] pix;
  logic [31:0] frame_beats;
  assign pix         = 32'(attr[31:16]) * 32'(attr[15:0]);
  assign frame_beats = 32'(({1'b0, pix} + 33'd1) >> 1);

  logic       hs;
  logic       beat;
  logic       lastbeat;
  logic [4:0] hs_len;
  assign hs       = axi.arvalid & axi.arready;
  assign beat     = axi.rvalid & axi.rready;
  assign lastbeat = beat & axi.rlast;
  assign hs_len   = hs ? ({1'b0, axi.arlen} + 5'd1) : 5'd0;

  // "a_" values already include a handshake completing this cycle, so the
  // next burst can be queued on the same edge (back-to-back requests).
  logic [31:0] a_addr;
  logic [31:0] a_remain;
  logic [9:0]  a_resv;
  logic [9:0]  resv_nxt;
  logic [3:0]  a_outst;
  logic [3:0]  outst_nxt;
  assign a_addr    = addr + {24'd0, hs_len, 3'd0};
  assign a_remain  = remain - {27'd0, hs_len};
  assign a_resv    = resv + {5'd0, hs_len};
  assign resv_nxt  = a_resv - {9'd0, beat};
  assign a_outst   = outst + {3'd0, hs};
  assign outst_nxt = a_outst - {3'd0, lastbeat};

  logic [31:0] cur_addr;
  logic [31:0] cur_remain;
  logic [9:0]  bnd;
  logic [4:0]  len;
  assign cur_addr   = (state == IDLE) ? base : a_addr;
  assign cur_remain = (state == IDLE) ? frame_beats : a_remain;
  assign bnd        = 10'd512 - {1'b0, cur_addr[11:3]};

  always_comb begin
    len = 5'(BURST);
    if (cur_remain < {27'd0, len}) len = cur_remain[4:0];
    if (bnd < {5'd0, len}) len = bnd[4:0];
  end

  logic can_issue;
  logic pending;
  logic drained;
  assign can_issue = (cur_remain != 32'd0) && (a_outst < 4'(MAXOUT)) &&
                     ({1'b0, fifo_free} >= ({1'b0, a_resv} + {6'd0, len})) &&
                     (!axi.arvalid || axi.arready);
  assign pending   = axi.arvalid & ~axi.arready;
  assign drained   = (outst_nxt == 4'd0) && (resv_nxt == 10'd0);

  assign fifo_wr    = beat;
  assign fifo_wdata = axi.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      resv        <= '0;
      outst       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      bcnt        <= '0;
      axi.araddr  <= '0;
      axi.arlen   <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      axi.rready <= 1'b1;
      done       <= 1'b0;
      addr       <= a_addr;
      remain     <= a_remain;
      resv       <= resv_nxt;
      outst      <= outst_nxt;

      if (hs) begin
        axi.arvalid <= 1'b0;
        lenq[wptr]  <= axi.arlen;
        wptr        <= (wptr == PW'(MAXOUT - 1)) ? '0 : wptr + 1'b1;
      end

      // Bursts return in order; the head of lenq is the burst now streaming.
      if (beat) begin
        if (axi.rlast) begin
          if (bcnt != lenq[rptr]) err <= 1'b1;
          bcnt <= '0;
          rptr <= (rptr == PW'(MAXOUT - 1)) ? '0 : rptr + 1'b1;
        end else begin
          if (bcnt == lenq[rptr]) err <= 1'b1;
          bcnt <= bcnt + 4'd1;
        end
      end

      if (dmastart && state != IDLE) err <= 1'b1;

      case (state)
        IDLE: begin
          if (dmastart) begin
            addr   <= base;
            remain <= frame_beats;
            busy   <= 1'b1;
            state  <= (frame_beats == 32'd0) ? FINISH : RUN;
            if (can_issue) begin
              axi.araddr  <= cur_addr;
              axi.arlen   <= 4'(len - 5'd1);
              axi.arvalid <= 1'b1;
            end
          end
        end
        RUN: begin
          if (can_issue) begin
            axi.araddr  <= cur_addr;
            axi.arlen   <= 4'(len - 5'd1);
            axi.arvalid <= 1'b1;
          end else if (a_remain == 32'd0 && !pending) begin
            if (drained) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          if (drained) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmaread.sv
// tb/tb_dmaread.sv - directed bench for dmaread with an in-order AXI read slave of programmable latency
module tb_dmaread;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] attr = '0;
  logic [31:0] base = '0;
  logic        dmastart = 1'b0;
  logic [63:0] fifo_wdata;
  logic        fifo_wr;
  logic [9:0]  fifo_free = 10'd512;
  logic        busy, done, err;

  dmaread_if bus();

  dmaread dut (
    .clk(clk), .reset(reset), .attr(attr), .base(base), .dmastart(dmastart),
    .axi(bus.master), .fifo_wdata(fifo_wdata), .fifo_wr(fifo_wr),
    .fifo_free(fifo_free), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int lat = 0;

  int          sq_len[$];
  int          sq_rdy[$];
  int          sidx = 0;
  logic [31:0] dseq = '0;

  logic [31:0] hs_addr[$];
  int          hs_len[$];
  int nbeats, ndone, done_cyc, last_rlast_cyc, outst_m, inflight, max_outst, max_inflight, data_bad;
  logic busy_at_done;

  always @(posedge clk) cyc = cyc + 1;

  // Slave: bursts served in order, first beat no earlier than lat+1 cycles after the handshake.
  always @(posedge clk) begin
    #1;
    if (!reset && sq_len.size() > 0 && cyc >= sq_rdy[0]) begin
      bus.rvalid = 1'b1;
      bus.rlast  = (sidx == sq_len[0]);
      bus.rdata  = {~dseq, dseq};
    end else begin
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      sq_len.delete();
      sq_rdy.delete();
      sidx = 0;
      outst_m = 0;
      inflight = 0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        hs_addr.push_back(bus.araddr);
        hs_len.push_back(int'(bus.arlen));
        sq_len.push_back(int'(bus.arlen));
        sq_rdy.push_back(cyc + 1 + lat);
        inflight += int'(bus.arlen) + 1;
        outst_m++;
      end
      if (bus.rvalid && bus.rready) begin
        if (fifo_wr !== 1'b1 || fifo_wdata !== {~dseq, dseq}) data_bad++;
        nbeats++;
        inflight--;
        dseq++;
        if (bus.rlast) begin
          outst_m--;
          last_rlast_cyc = cyc;
          void'(sq_len.pop_front());
          void'(sq_rdy.pop_front());
          sidx = 0;
        end else begin
          sidx++;
        end
      end else if (fifo_wr === 1'b1) begin
        data_bad++;
      end
      if (outst_m > max_outst) max_outst = outst_m;
      if (inflight > max_inflight) max_inflight = inflight;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_addr.delete();
    hs_len.delete();
    nbeats = 0; ndone = 0; done_cyc = -1; last_rlast_cyc = -100;
    max_outst = 0; max_inflight = 0; data_bad = 0; busy_at_done = 1'bx;
  endtask

  task automatic start_frame(input logic [15:0] h, input logic [15:0] v, input logic [31:0] b);
    attr = {h, v};
    base = b;
    dmastart = 1'b1;
    tick();
    dmastart = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      if (ndone > 0) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset = 1'b1;
    bus.arready = 1'b1;
    bus.rvalid = 1'b0;
    bus.rlast = 1'b0;
    bus.rdata = '0;
    repeat (3) tick();
    got = {bus.arvalid, |bus.araddr, |bus.arlen, busy, done, err, bus.rready, fifo_wr};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs got=%b exp=00000000", got);
    end
    reset = 1'b0;
    tick();
    compared++;
    if (bus.rready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release rready=%b busy=%b exp rready=1 busy=0", bus.rready, busy);
    end
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    lat = 0;
    fifo_free = 10'd512;
    start_frame(16'd64, 16'd2, 32'h1000);
    compared++;
    if (busy !== 1'b1 || bus.arvalid !== 1'b1 || bus.araddr !== 32'h1000 || bus.arlen !== 4'd15) begin
      mismatched++;
      $display("FAIL basic_first_req busy=%b arvalid=%b araddr=%h arlen=%0d exp 1 1 1000 15",
               busy, bus.arvalid, bus.araddr, bus.arlen);
    end
    tick();
    compared++;
    if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1080) begin
      mismatched++;
      $display("FAIL basic_back_to_back arvalid=%b araddr=%h exp 1 1080", bus.arvalid, bus.araddr);
    end
    wait_done(300, to);
    compared++;
    if (to) begin
      mismatched++;
      $display("FAIL basic_timeout done not seen within 300 cycles");
    end
    compared++;
    if (hs_addr.size() != 4) begin
      mismatched++;
      $display("FAIL basic_burst_count got=%0d exp=4", hs_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (i >= hs_addr.size() || hs_addr[i] !== 32'h1000 + 32'(i * 128) || hs_len[i] != 15) begin
        mismatched++;
        $display("FAIL basic_burst%0d got addr=%h len=%0d exp addr=%h len=15", i,
                 (i < hs_addr.size()) ? hs_addr[i] : 32'hffffffff,
                 (i < hs_len.size()) ? hs_len[i] : -1, 32'h1000 + 32'(i * 128));
      end
    end
    compared++;
    if (nbeats != 64 || ndone != 1 || data_bad != 0) begin
      mismatched++;
      $display("FAIL basic_data writes=%0d dones=%0d bad=%0d exp 64 1 0", nbeats, ndone, data_bad);
    end
    compared++;
    if (done_cyc != last_rlast_cyc + 1 || busy_at_done !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_done_timing done_cyc=%0d busy=%b exp cyc=%0d busy=0",
               done_cyc, busy_at_done, last_rlast_cyc + 1);
    end
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_err got=%b exp=0", err);
    end
  endtask

  task automatic test_split();
    bit to;
    clear_mon();
    start_frame(16'd32, 16'd1, 32'h1FC0);
    wait_done(200, to);
    compared++;
    if (to || hs_addr.size() != 2 || nbeats != 16 || ndone != 1) begin
      mismatched++;
      $display("FAIL split_summary to=%0d bursts=%0d writes=%0d dones=%0d exp 0 2 16 1",
               to, hs_addr.size(), nbeats, ndone);
    end else begin
      compared++;
      if (hs_addr[0] !== 32'h1FC0 || hs_len[0] != 7 || hs_addr[1] !== 32'h2000 || hs_len[1] != 7) begin
        mismatched++;
        $display("FAIL split_bursts got %h/%0d %h/%0d exp 1fc0/7 2000/7",
                 hs_addr[0], hs_len[0], hs_addr[1], hs_len[1]);
      end
    end
  endtask

  task automatic test_odd();
    bit to;
    clear_mon();
    start_frame(16'd3, 16'd1, 32'h3000);
    wait_done(100, to);
    compared++;
    if (to || hs_addr.size() != 1 || nbeats != 2 || ndone != 1) begin
      mismatched++;
      $display("FAIL odd_summary to=%0d bursts=%0d writes=%0d dones=%0d exp 0 1 2 1",
               to, hs_addr.size(), nbeats, ndone);
    end else begin
      compared++;
      if (hs_len[0] != 1 || hs_addr[0] !== 32'h3000) begin
        mismatched++;
        $display("FAIL odd_burst got %h/%0d exp 3000/1", hs_addr[0], hs_len[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_mon();
    lat = 50;
    fifo_free = 10'd20;
    start_frame(16'd64, 16'd2, 32'h4000);
    repeat (40) tick();
    compared++;
    if (hs_addr.size() != 1 || outst_m != 1) begin
      mismatched++;
      $display("FAIL bp_single_outstanding bursts=%0d outst=%0d exp 1 1", hs_addr.size(), outst_m);
    end
    wait_done(800, to);
    compared++;
    if (to || nbeats != 64 || hs_addr.size() != 4) begin
      mismatched++;
      $display("FAIL bp_frame to=%0d writes=%0d bursts=%0d exp 0 64 4", to, nbeats, hs_addr.size());
    end
    compared++;
    if (max_inflight > 20) begin
      mismatched++;
      $display("FAIL bp_credit max_inflight=%0d exp <=20", max_inflight);
    end
    clear_mon();
    fifo_free = 10'd512;
    start_frame(16'd64, 16'd4, 32'h8000);
    wait_done(800, to);
    compared++;
    if (to || max_outst != 4 || hs_addr.size() != 8 || nbeats != 128) begin
      mismatched++;
      $display("FAIL bp_maxout to=%0d max_outst=%0d bursts=%0d writes=%0d exp 0 4 8 128",
               to, max_outst, hs_addr.size(), nbeats);
    end
    lat = 0;
  endtask

  task automatic test_error_restart();
    bit to;
    clear_mon();
    start_frame(16'd64, 16'd2, 32'h5000);
    tick();
    attr = {16'd8, 16'd8};
    base = 32'h9000;
    dmastart = 1'b1;
    tick();
    dmastart = 1'b0;
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL err_late_start got=%b exp=1", err);
    end
    wait_done(300, to);
    compared++;
    if (to || hs_addr.size() != 4 || nbeats != 64 || ndone != 1) begin
      mismatched++;
      $display("FAIL err_frame to=%0d bursts=%0d writes=%0d dones=%0d exp 0 4 64 1",
               to, hs_addr.size(), nbeats, ndone);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (i >= hs_addr.size() || hs_addr[i] !== 32'h5000 + 32'(i * 128)) begin
        mismatched++;
        $display("FAIL err_addr%0d got=%h exp=%h", i,
                 (i < hs_addr.size()) ? hs_addr[i] : 32'hffffffff, 32'h5000 + 32'(i * 128));
      end
    end
  endtask

  task automatic test_zero_frame();
    clear_mon();
    start_frame(16'd16, 16'd0, 32'hA000);
    compared++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_t1 busy=%b done=%b exp 1 0", busy, done);
    end
    tick();
    compared++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_t2 done=%b busy=%b exp 1 0", done, busy);
    end
    tick();
    compared++;
    if (hs_addr.size() != 0 || ndone != 1 || err !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_after bursts=%0d dones=%0d err=%b exp 0 1 1", hs_addr.size(), ndone, err);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [7:0] got;
    clear_mon();
    lat = 50;
    fifo_free = 10'd512;
    bus.arready = 1'b1;
    start_frame(16'd64, 16'd4, 32'hB000);
    tick();
    tick();
    tick();
    bus.arready = 1'b0;
    tick();
    compared++;
    if (bus.arvalid !== 1'b1 || outst_m != 3 || bus.araddr !== 32'hB180) begin
      mismatched++;
      $display("FAIL rst_setup arvalid=%b outst=%0d araddr=%h exp 1 3 b180", bus.arvalid, outst_m, bus.araddr);
    end
    reset = 1'b1;
    tick();
    got = {bus.arvalid, |bus.araddr, |bus.arlen, busy, done, err, bus.rready, fifo_wr};
    compared++;
    if (got !== 8'h00) begin
      mismatched++;
      $display("FAIL rst_mid_outputs got=%b exp=00000000", got);
    end
    reset = 1'b0;
    bus.arready = 1'b1;
    lat = 0;
    tick();
    clear_mon();
    start_frame(16'd64, 16'd2, 32'h6000);
    wait_done(300, to);
    compared++;
    if (to || hs_addr.size() != 4 || nbeats != 64 || ndone != 1 || err !== 1'b0 || data_bad != 0) begin
      mismatched++;
      $display("FAIL rst_refetch to=%0d bursts=%0d writes=%0d dones=%0d err=%b bad=%0d exp 0 4 64 1 0 0",
               to, hs_addr.size(), nbeats, ndone, err, data_bad);
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (i >= hs_addr.size() || hs_addr[i] !== 32'h6000 + 32'(i * 128) || hs_len[i] != 15) begin
        mismatched++;
        $display("FAIL rst_addr%0d got=%h exp=%h len 15", i,
                 (i < hs_addr.size()) ? hs_addr[i] : 32'hffffffff, 32'h6000 + 32'(i * 128));
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_split();
    test_odd();
    test_backpressure();
    test_error_restart();
    test_zero_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
